// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU sharing arbiter.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OP_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_ANDI = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic port_id_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unsupported op codes pass src1 through unchanged.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OP_W  = ALU_OP_W
) (
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  always_comb begin
    alu_result = src1;
    case (alu_op)
      OP_W'(ALU_ADD):  alu_result = src1 + src2;
      OP_W'(ALU_SUB):  alu_result = src1 - src2;
      OP_W'(ALU_OR):   alu_result = src1 | src2;
      OP_W'(ALU_SRL):  alu_result = src1 >> src2[SH_W-1:0];
      OP_W'(ALU_ANDI): alu_result = src1 & src2;
      default:         alu_result = src1;
    endcase
    zero = (alu_result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// Operands are captured before the ALU and the result is captured after it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic [WIDTH-1:0] p0_src1,
  input  logic [WIDTH-1:0] p0_src2,
  input  logic [OP_W-1:0]  p0_op,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic [WIDTH-1:0] p1_src1,
  input  logic [WIDTH-1:0] p1_src2,
  input  logic [OP_W-1:0]  p1_op,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  state_e           state_q, state_d;
  port_id_t         owner_q, owner_d;
  port_id_t         last_grant_q, last_grant_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             p0_rsp_valid_q, p0_rsp_valid_d;
  logic             p1_rsp_valid_q, p1_rsp_valid_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  port_id_t         winner;
  logic             owner_rsp_ready;

  alu #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_alu (
    .src1       (src1_q),
    .src2       (src2_q),
    .alu_op     (op_q),
    .alu_result (alu_result),
    .zero       (alu_zero)
  );

  // Tie goes to the port that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (p0_req_valid && p1_req_valid) begin
      winner = ~last_grant_q;
    end else if (p1_req_valid) begin
      winner = 1'b1;
    end
  end

  assign p0_req_ready    = (state_q == IDLE) && p0_req_valid && (winner == 1'b0);
  assign p1_req_ready    = (state_q == IDLE) && p1_req_valid && (winner == 1'b1);
  assign owner_rsp_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    src1_d         = src1_q;
    src2_d         = src2_q;
    op_d           = op_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    p0_rsp_valid_d = p0_rsp_valid_q;
    p1_rsp_valid_d = p1_rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          state_d      = EXEC;
          owner_d      = winner;
          last_grant_d = winner;
          src1_d       = winner ? p1_src1 : p0_src1;
          src2_d       = winner ? p1_src2 : p0_src2;
          op_d         = winner ? p1_op   : p0_op;
        end
      end
      EXEC: begin
        state_d        = RESP;
        rsp_result_d   = alu_result;
        rsp_zero_d     = alu_zero;
        p0_rsp_valid_d = (owner_q == 1'b0);
        p1_rsp_valid_d = (owner_q == 1'b1);
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d        = IDLE;
          p0_rsp_valid_d = 1'b0;
          p1_rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d        = IDLE;
        p0_rsp_valid_d = 1'b0;
        p1_rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      src1_q         <= '0;
      src2_q         <= '0;
      op_q           <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      src1_q         <= src1_d;
      src2_q         <= src2_d;
      op_q           <= op_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      p0_rsp_valid_q <= p0_rsp_valid_d;
      p1_rsp_valid_q <= p1_rsp_valid_d;
    end
  end

  assign p0_rsp_valid = p0_rsp_valid_q;
  assign p1_rsp_valid = p1_rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios plus random traffic on both ports.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
  logic          p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
  logic [W-1:0]  p0_src1, p0_src2, p1_src1, p1_src2, rsp_result;
  logic [OW-1:0] p0_op, p1_op;
  logic          rsp_zero;

  alu_share_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_src1(p0_src1), .p0_src2(p0_src2), .p0_op(p0_op),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_src1(p1_src1), .p1_src2(p1_src2), .p1_op(p1_op),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [W-1:0] res;
    logic        zero;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  int   dut_grants[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference ALU straight from the op table; unknown codes return src1.
  function automatic logic [W:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    if (op == ALU_ADD)       r = a + b;
    else if (op == ALU_SUB)  r = a - b;
    else if (op == ALU_OR)   r = a | b;
    else if (op == ALU_SRL)  r = a >> (b % W);
    else if (op == ALU_ANDI) r = a & b;
    else                     r = a;
    return {(r == '0), r};
  endfunction

  // Request-side model: which port may be accepted, and what it must return.
  int       phase = 0;
  int       m_owner = 0;
  logic     m_last = 1'b1;
  int       foreign [2];
  int       m_win;
  logic     m_e0, m_e1;
  logic [W:0] m_r;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0; m_last = 1'b1; foreign[0] = 0; foreign[1] = 0;
    end else begin
      if (p0_req_valid && p1_req_valid) m_win = m_last ? 0 : 1;
      else                              m_win = p1_req_valid ? 1 : 0;
      m_e0 = (phase == 0) && p0_req_valid && (m_win == 0);
      m_e1 = (phase == 0) && p1_req_valid && (m_win == 1);
      check("p0_req_ready", 64'(p0_req_ready), 64'(m_e0));
      check("p1_req_ready", 64'(p1_req_ready), 64'(m_e1));
      if (p0_req_ready)      dut_grants.push_back(0);
      else if (p1_req_ready) dut_grants.push_back(1);
      if (phase == 0) begin
        if (p0_req_valid || p1_req_valid) begin
          if (m_win == 0 ? p1_req_valid : p0_req_valid) foreign[1 - m_win]++;
          check("wait_foreign_ops_le1", 64'(foreign[m_win] <= 1), 64'd1);
          foreign[m_win] = 0;
          if (m_win == 0) m_r = ref_alu(p0_op, p0_src1, p0_src2);
          else            m_r = ref_alu(p1_op, p1_src1, p1_src2);
          sb.push_back('{m_win, m_r[W-1:0], m_r[W], cyc});
          m_last  = (m_win == 1);
          m_owner = m_win;
          phase   = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (m_owner == 0 ? p0_rsp_ready : p1_rsp_ready) begin
        phase = 0;
      end
    end
  end

  // Response monitor: response is due two cycles after acceptance, held until consumed.
  int   r_own;
  logic r_own_v, r_oth_v;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (sb.size() > 0 && cyc >= sb[0].acc + 2) begin
      r_own   = sb[0].port;
      r_own_v = (r_own == 0) ? p0_rsp_valid : p1_rsp_valid;
      r_oth_v = (r_own == 0) ? p1_rsp_valid : p0_rsp_valid;
      check("rsp_valid_owner", 64'(r_own_v), 64'd1);
      check("rsp_valid_other", 64'(r_oth_v), 64'd0);
      check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
      check("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
      if (r_own == 0 ? p0_rsp_ready : p1_rsp_ready) void'(sb.pop_front());
    end else begin
      check("p0_rsp_valid_idle", 64'(p0_rsp_valid), 64'd0);
      check("p1_rsp_valid_idle", 64'(p1_rsp_valid), 64'd0);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      p0_rsp_ready = ($urandom_range(0, 3) != 0);
      p1_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_req(input int p, input logic v, input logic [OW-1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (p == 0) begin p0_req_valid = v; p0_op = op; p0_src1 = a; p0_src2 = b; end
    else        begin p1_req_valid = v; p1_op = op; p1_src1 = a; p1_src2 = b; end
  endtask

  // Hold a request until accepted; returns just after the accepting edge.
  task automatic issue(input int p, input logic [OW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bit done = 1'b0;
    drive_req(p, 1'b1, op, a, b);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (p == 0 ? p0_req_ready : p1_req_ready) begin done = 1'b1; break; end
    end
    check("issue_accepted", 64'(done), 64'd1);
    @(posedge clk); #1;
    drive_req(p, 1'b0, op, a, b);
  endtask

  task automatic wait_rsp(input int p, input logic [W-1:0] er, input logic ez);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p == 0 ? p0_rsp_valid : p1_rsp_valid) begin seen = 1'b1; break; end
    end
    check("dir_rsp_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("dir_result", 64'(rsp_result), 64'(er));
      check("dir_zero", 64'(rsp_zero), 64'(ez));
      check("dir_other_valid", 64'(p == 0 ? p1_rsp_valid : p0_rsp_valid), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      logic [OW-1:0] op;
      logic [W-1:0]  a, b;
      int            sel, gap;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: op = ALU_ADD;
        1: op = ALU_SUB;
        2: op = ALU_OR;
        3: op = ALU_SRL;
        4: op = ALU_ANDI;
        default: op = OW'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      issue(p, op, a, b);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("reset_p0_rsp_valid", 64'(p0_rsp_valid), 64'd0);
    check("reset_p1_rsp_valid", 64'(p1_rsp_valid), 64'd0);
    check("reset_rsp_result", 64'(rsp_result), 64'd0);
    check("reset_rsp_zero", 64'(rsp_zero), 64'd0);
    check("reset_p0_req_ready", 64'(p0_req_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // p0 alone
    fork
      issue(0, ALU_SUB, 32'd10, 32'd5);
      wait_rsp(0, 32'd5, 1'b0);
    join
    // p1 alone
    fork
      issue(1, ALU_ANDI, 32'd5, 32'd15);
      wait_rsp(1, 32'd5, 1'b0);
    join
    fork
      issue(1, ALU_SRL, 32'd15, 32'd1);
      wait_rsp(1, 32'd7, 1'b0);
    join

    // Both ports requesting continuously from reset
    do_reset();
    dut_grants.delete();
    fork
      begin issue(0, ALU_SUB, 32'd10, 32'd10); issue(0, ALU_ADD, 32'd1, 32'd1); end
      begin issue(1, ALU_OR, 32'd10, 32'd5);   issue(1, ALU_SUB, 32'd3, 32'd1); end
      wait_rsp(0, 32'd0, 1'b1);
      wait_rsp(1, 32'd15, 1'b0);
    join
    repeat (4) @(posedge clk); #1;
    check("grant_count", 64'(dut_grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      check("grant_order", 64'(dut_grants[i]), 64'(i % 2));

    // Owner stalls its response while the other port waits
    p0_rsp_ready = 1'b0;
    fork
      issue(0, ALU_ADD, 32'd7, 32'd8);
      begin @(posedge clk); #1; issue(1, ALU_OR, 32'd3, 32'd4); end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (p0_rsp_valid) begin seen = 1'b1; break; end
        end
        check("stall_rsp_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_p0_rsp_valid", 64'(p0_rsp_valid), 64'd1);
          check("stall_rsp_result", 64'(rsp_result), 64'd15);
          check("stall_p1_req_ready", 64'(p1_req_ready), 64'd0);
        end
        @(posedge clk); #1 p0_rsp_ready = 1'b1;
      end
      begin repeat (3) @(posedge clk); wait_rsp(1, 32'd7, 1'b0); end
    join

    // Reset while the operation is executing
    issue(0, ALU_SUB, 32'd20, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_p0_rsp_valid", 64'(p0_rsp_valid), 64'd0);
    check("midrst_p1_rsp_valid", 64'(p1_rsp_valid), 64'd0);
    check("midrst_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    dut_grants.delete();
    fork
      issue(0, ALU_ADD, 32'd1, 32'd2);
      issue(1, ALU_ADD, 32'd3, 32'd4);
      wait_rsp(0, 32'd3, 1'b0);
    join
    check("post_reset_first_grant", 64'(dut_grants.size() > 0 ? dut_grants[0] : 9), 64'd0);

    // Random traffic, 1000 ops in total
    rand_rdy = 1'b1;
    fork
      rand_port(0, 500);
      rand_port(1, 500);
    join
    for (int i = 0; i < 500 && sb.size() > 0; i++) @(posedge clk);
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
